sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Round-robin arbiter that funnels NUM_REQ requesters onto a single SRAM
// controller command/response channel. Only one transaction is in flight at a
// time. The FSM walks IDLE -> ISSUE -> WAIT_RSP -> IDLE.
//
// Optional feature macro: SRAM_ARB_WDOG_EN
//   When defined, a response watchdog is added. If the controller does not
//   answer within WDOG_CYCLES cycles of entering WAIT_RSP, the transaction is
//   closed with a done_o pulse and a one-cycle wdog_err_o pulse.
//
// Ports
//   sram_clk     in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   req_i        in   per-requester request level
//   wr_en_i      in   per-requester write(1)/read(0)
//   addr_i       in   packed addresses, requester k at slice k
//   wdata_i      in   packed write data, requester k at slice k
//   gnt_o        out  one-hot owner of the current transaction, 0 when idle
//   done_o       out  one-cycle completion pulse to the owner
//   rdata_o      out  last read data
//   cmd_valid_o  out  command valid to the controller
//   cmd_ready_i  in   controller accepts the command
//   cmd_wr_en_o  out  registered command write enable
//   cmd_addr_o   out  registered command address
//   cmd_wdata_o  out  registered command write data
//   wdog_err_o   out  watchdog expiry pulse (SRAM_ARB_WDOG_EN only)
//   rsp_valid_i  in   controller completion pulse
//   rsp_rdata_i  in   controller read data
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int WDOG_CYCLES = 255
) (
   input  logic                          sram_clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            wr_en_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          cmd_valid_o,
   input  logic                          cmd_ready_i,
   output logic                          cmd_wr_en_o,
   output logic [ADDR_WIDTH-1:0]         cmd_addr_o,
   output logic [DATA_WIDTH-1:0]         cmd_wdata_o,
`ifdef SRAM_ARB_WDOG_EN
   output logic                          wdog_err_o,
`endif
   input  logic                          rsp_valid_i,
   input  logic [DATA_WIDTH-1:0]         rsp_rdata_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       owner_q;
   logic [IDX_W-1:0]       last_owner_q;
   logic [NUM_REQ-1:0]     gnt_q;
   logic [NUM_REQ-1:0]     done_q;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic                   cmd_valid_q;
   logic                   cmd_wr_en_q;
   logic [ADDR_WIDTH-1:0]  cmd_addr_q;
   logic [DATA_WIDTH-1:0]  cmd_wdata_q;

   // Arbitration result for the next grant (combinational).
   logic                   win_valid_d;
   logic [IDX_W-1:0]       win_idx_d;

   // Unpacked per-requester views of the packed buses.
   logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Round-robin search starting at last_owner+1. The loop runs from the
   // farthest offset down to the nearest so the nearest requesting index is
   // the last assignment and therefore wins.
   always_comb begin
      win_valid_d = 1'b0;
      win_idx_d   = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         int cand;
         cand = (int'(last_owner_q) + i) % NUM_REQ;
         if (req_i[IDX_W'(cand)]) begin
            win_valid_d = 1'b1;
            win_idx_d   = IDX_W'(cand);
         end
      end
   end

`ifdef SRAM_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_cnt_q;
   logic              wdog_err_q;
   assign wdog_err_o = wdog_err_q;
`else
   logic wdog_unused;
   assign wdog_unused = |WDOG_CYCLES;
`endif

   always_ff @(posedge sram_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
         gnt_q        <= '0;
         done_q       <= '0;
         rdata_q      <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_wr_en_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
`ifdef SRAM_ARB_WDOG_EN
         wdog_cnt_q   <= '0;
         wdog_err_q   <= 1'b0;
`endif
      end else begin
         done_q <= '0;
`ifdef SRAM_ARB_WDOG_EN
         wdog_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               // The cycle carrying the done pulse is spent idle, so a new
               // command can rise no earlier than two cycles after done.
               if (win_valid_d && (done_q == '0)) begin
                  owner_q     <= win_idx_d;
                  gnt_q       <= NUM_REQ'(1) << win_idx_d;
                  cmd_valid_q <= 1'b1;
                  cmd_wr_en_q <= wr_en_i[win_idx_d];
                  cmd_addr_q  <= addr_arr[win_idx_d];
                  cmd_wdata_q <= wdata_arr[win_idx_d];
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_ready_i) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= WAIT_RSP;
`ifdef SRAM_ARB_WDOG_EN
                  wdog_cnt_q  <= '0;
`endif
               end
            end
            WAIT_RSP: begin
               if (rsp_valid_i) begin
                  done_q[owner_q] <= 1'b1;
                  if (!cmd_wr_en_q) begin
                     rdata_q <= rsp_rdata_i;
                  end
                  last_owner_q <= owner_q;
                  gnt_q        <= '0;
                  state_q      <= IDLE;
               end
`ifdef SRAM_ARB_WDOG_EN
               else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                  // Give up on the controller: close the transaction without
                  // touching rdata.
                  done_q[owner_q] <= 1'b1;
                  wdog_err_q      <= 1'b1;
                  last_owner_q    <= owner_q;
                  gnt_q           <= '0;
                  state_q         <= IDLE;
               end else begin
                  wdog_cnt_q <= wdog_cnt_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q     <= IDLE;
               gnt_q       <= '0;
               cmd_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign rdata_o     = rdata_q;
   assign cmd_valid_o = cmd_valid_q;
   assign cmd_wr_en_o = cmd_wr_en_q;
   assign cmd_addr_o  = cmd_addr_q;
   assign cmd_wdata_o = cmd_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter (NUM_REQ=4, ADDR_WIDTH=8, DATA_WIDTH=16,
// WDOG_CYCLES=10). Inputs are driven and outputs sampled on the falling edge.
// The watchdog scenario is compiled only when SRAM_ARB_WDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int NR = 4;
   localparam int AW = 8;
   localparam int DW = 16;

   logic             sram_clk;
   logic             rst;
   logic [NR-1:0]    req_i;
   logic [NR-1:0]    wr_en_i;
   logic [NR*AW-1:0] addr_i;
   logic [NR*DW-1:0] wdata_i;
   logic [NR-1:0]    gnt_o;
   logic [NR-1:0]    done_o;
   logic [DW-1:0]    rdata_o;
   logic             cmd_valid_o;
   logic             cmd_ready_i;
   logic             cmd_wr_en_o;
   logic [AW-1:0]    cmd_addr_o;
   logic [DW-1:0]    cmd_wdata_o;
   logic             rsp_valid_i;
   logic [DW-1:0]    rsp_rdata_i;
`ifdef SRAM_ARB_WDOG_EN
   logic             wdog_err_o;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   sram_arbiter #(
      .NUM_REQ     (NR),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .WDOG_CYCLES (10)
   ) dut (
      .sram_clk    (sram_clk),
      .rst         (rst),
      .req_i       (req_i),
      .wr_en_i     (wr_en_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .done_o      (done_o),
      .rdata_o     (rdata_o),
      .cmd_valid_o (cmd_valid_o),
      .cmd_ready_i (cmd_ready_i),
      .cmd_wr_en_o (cmd_wr_en_o),
      .cmd_addr_o  (cmd_addr_o),
      .cmd_wdata_o (cmd_wdata_o),
`ifdef SRAM_ARB_WDOG_EN
      .wdog_err_o  (wdog_err_o),
`endif
      .rsp_valid_i (rsp_valid_i),
      .rsp_rdata_i (rsp_rdata_i)
   );

   initial sram_clk = 1'b0;
   always #5 sram_clk = ~sram_clk;

   // Hard stop so the run always ends even if the sequence stalls.
   initial begin
      #200000;
      $display("FAIL timeout: observed no end of sequence, expected finish");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge sram_clk);
      @(negedge sram_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-16s observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      rst         = 1'b1;
      req_i       = '0;
      wr_en_i     = '0;
      addr_i      = '0;
      wdata_i     = '0;
      cmd_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_rdata_i = '0;
      repeat (2) @(negedge sram_clk);
      rst = 1'b0;

      // Reset state
      chk("rst_gnt",   32'(gnt_o),       32'h0);
      chk("rst_done",  32'(done_o),      32'h0);
      chk("rst_valid", 32'(cmd_valid_o), 32'h0);
      chk("rst_addr",  32'(cmd_addr_o),  32'h0);
      chk("rst_wdata", 32'(cmd_wdata_o), 32'h0);
      chk("rst_rdata", 32'(rdata_o),     32'h0);
`ifdef SRAM_ARB_WDOG_EN
      chk("rst_wdog",  32'(wdog_err_o),  32'h0);
`endif

      // Write from requester 0; rsp two cycles after handshake.
      req_i         = 4'b0001;
      wr_en_i       = 4'b0001;
      addr_i[7:0]   = 8'h3C;
      wdata_i[15:0] = 16'hBEEF;
      cmd_ready_i   = 1'b1;
      tick();
      chk("w0_valid", 32'(cmd_valid_o), 32'h1);
      chk("w0_addr",  32'(cmd_addr_o),  32'h3C);
      chk("w0_wdata", 32'(cmd_wdata_o), 32'hBEEF);
      chk("w0_wr",    32'(cmd_wr_en_o), 32'h1);
      chk("w0_gnt",   32'(gnt_o),       32'h1);
      req_i = '0;
      tick();
      chk("w0_hs_valid", 32'(cmd_valid_o), 32'h0);
      chk("w0_hs_gnt",   32'(gnt_o),       32'h1);
      tick();
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 16'hFFFF;
      tick();
      rsp_valid_i = 1'b0;
      chk("w0_done",  32'(done_o),  32'h1);
      chk("w0_gnt0",  32'(gnt_o),   32'h0);
      chk("w0_rdata", 32'(rdata_o), 32'h0);
      tick();
      chk("w0_done_off", 32'(done_o),      32'h0);
      chk("w0_idle",     32'(cmd_valid_o), 32'h0);

      // Read from requester 2.
      req_i           = 4'b0100;
      wr_en_i         = 4'b0000;
      addr_i[23:16]   = 8'h10;
      tick();
      chk("r2_gnt",  32'(gnt_o),       32'h4);
      chk("r2_addr", 32'(cmd_addr_o),  32'h10);
      chk("r2_wr",   32'(cmd_wr_en_o), 32'h0);
      req_i = '0;
      tick();
      chk("r2_gnt_wait", 32'(gnt_o), 32'h4);
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 16'h1234;
      tick();
      rsp_valid_i = 1'b0;
      chk("r2_done",  32'(done_o),  32'h4);
      chk("r2_rdata", 32'(rdata_o), 32'h1234);
      chk("r2_gnt0",  32'(gnt_o),   32'h0);
      tick();
      chk("r2_rdata_after", 32'(rdata_o), 32'h1234);

      // Stray response in IDLE is ignored.
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 16'h5555;
      tick();
      rsp_valid_i = 1'b0;
      chk("stray_done",  32'(done_o),  32'h0);
      chk("stray_rdata", 32'(rdata_o), 32'h1234);

      // Fairness: all requesters, 8 back-to-back reads.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NR; k++) addr_i[k*AW +: AW] = 8'(8'h20 + k);
      wr_en_i     = 4'b0000;
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 16'h0F0F;
      req_i       = 4'b1111;
      tick();
      for (int t = 0; t < 8; t++) begin
         chk($sformatf("rr%0d_gnt", t),  32'(gnt_o),      32'(1 << (t % 4)));
         chk($sformatf("rr%0d_addr", t), 32'(cmd_addr_o), 32'(8'h20 + (t % 4)));
         tick();
         chk($sformatf("rr%0d_wait", t), 32'(cmd_valid_o), 32'h0);
         tick();
         chk($sformatf("rr%0d_done", t), 32'(done_o), 32'(1 << (t % 4)));
         if (t == 7) req_i = '0;
         tick();
         chk($sformatf("rr%0d_gap", t), 32'(cmd_valid_o), 32'h0);
         tick();
      end
      rsp_valid_i = 1'b0;
      chk("rr_dropped", 32'(cmd_valid_o), 32'h0);

      // Backpressure: ready low for 5 ISSUE cycles; fields must not move.
      req_i           = 4'b0010;
      wr_en_i         = 4'b0010;
      addr_i[15:8]    = 8'h55;
      wdata_i[31:16]  = 16'hA5A5;
      cmd_ready_i     = 1'b0;
      tick();
      chk("bp_gnt", 32'(gnt_o), 32'h2);
      req_i          = '0;
      addr_i[15:8]   = 8'hAA;
      wdata_i[31:16] = 16'h0000;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp%0d_valid", i), 32'(cmd_valid_o), 32'h1);
         chk($sformatf("bp%0d_addr", i),  32'(cmd_addr_o),  32'h55);
         chk($sformatf("bp%0d_wdata", i), 32'(cmd_wdata_o), 32'hA5A5);
         if (i == 5) cmd_ready_i = 1'b1;
         tick();
      end
      chk("bp_hs",     32'(cmd_valid_o), 32'h0);
      tick();
      chk("bp_single", 32'(cmd_valid_o), 32'h0);
      rsp_valid_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      chk("bp_done",  32'(done_o),  32'h2);
      chk("bp_rdata", 32'(rdata_o), 32'h0F0F);
      tick();

      // Reset while waiting for the response.
      req_i       = 4'b0001;
      wr_en_i     = 4'b0000;
      addr_i[7:0] = 8'h77;
      tick();
      req_i = '0;
      tick();
      chk("mr_gnt", 32'(gnt_o), 32'h1);
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 16'h9999;
      tick();
      rsp_valid_i = 1'b0;
      chk("mr_done",  32'(done_o),      32'h0);
      chk("mr_gnt0",  32'(gnt_o),       32'h0);
      chk("mr_valid", 32'(cmd_valid_o), 32'h0);
      chk("mr_addr",  32'(cmd_addr_o),  32'h0);
      chk("mr_rdata", 32'(rdata_o),     32'h0);

      // After reset the search starts at 0: requesters 2,3 -> 2 wins.
      req_i = 4'b1100;
      tick();
      chk("post_gnt", 32'(gnt_o), 32'h4);
      req_i = '0;
      tick();
      rsp_valid_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      chk("post_done", 32'(done_o), 32'h4);
      tick();

`ifdef SRAM_ARB_WDOG_EN
      // Watchdog: no response, expiry 10 cycles after entering WAIT_RSP.
      rsp_rdata_i = 16'h4444;
      req_i       = 4'b0001;
      wr_en_i     = 4'b0000;
      tick();
      req_i = '0;
      tick();
      for (int k = 1; k < 10; k++) begin
         tick();
         chk($sformatf("wd%0d_quiet", k), 32'(wdog_err_o), 32'h0);
      end
      tick();
      chk("wd_err",   32'(wdog_err_o), 32'h1);
      chk("wd_done",  32'(done_o),     32'h1);
      chk("wd_gnt0",  32'(gnt_o),      32'h0);
      chk("wd_rdata", 32'(rdata_o),    32'h0);
      tick();
      chk("wd_err_off", 32'(wdog_err_o), 32'h0);
      req_i = 4'b0010;
      tick();
      chk("wd_next_gnt", 32'(gnt_o), 32'h2);
      req_i = '0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
